wb_ctrl: RTL

Writeback-stage controller for the three-stage pipeline. Decodes the instruction leaving the execute stage, registers the writeback control word (data-memory source select, load type, writeback-mux select, register-file write enable, destination register) into the writeback stage, and sequences multi-cycle memory-mapped IO loads with a request/acknowledge handshake, a pipeline stall and a timeout.

---
 rtl/wb_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_ctrl: writeback-stage control register and IO load sequencer        |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module wb_ctrl #(
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_x,
    input  logic [31:0] instruction_x,
    input  logic [31:0] alu_addr_x,
    input  logic        io_ack,
    output logic [1:0]  DMEM_sel,
    output logic [2:0]  LOAD_sel,
    output logic [1:0]  WB_sel,
    output logic        wb_en,
    output logic [4:0]  rd_wb,
    output logic        io_req,
    output logic        stall,
    output logic        io_err
);

    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_OP     = 7'b0110011;
    localparam logic [6:0]  c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
    localparam logic [15:0] c_WAIT_LAST = 16'(IO_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_IO_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_wait_cnt;

    logic [1:0]  r_dmem_sel;
    logic [2:0]  r_load_sel;
    logic [1:0]  r_wb_sel;
    logic        r_wb_en;
    logic [4:0]  r_rd;
    logic        r_io_req;
    logic        r_io_err;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [1:0]  w_dmem_sel;
    logic [2:0]  w_load_sel;
    logic [1:0]  w_wb_sel;
    logic        w_wb_en;
    logic        w_is_io;
    logic        w_timeout;
    logic        w_stall;
    logic        w_cap_io;
    logic        w_unused_bits;

    assign w_opcode      = instruction_x[6:0];
    assign w_rd          = instruction_x[11:7];
    assign w_unused_bits = ^{instruction_x[31:15], alu_addr_x[27:0]};

    always_comb begin
        w_dmem_sel = 2'd0;
        w_load_sel = 3'd0;
        w_wb_sel   = 2'd3;
        w_wb_en    = 1'b0;
        w_is_io    = 1'b0;
        case (w_opcode)
            c_OP_LUI: begin
                w_wb_sel = 2'd0;
                w_wb_en  = (w_rd != 5'd0);
            end
            c_OP_JAL, c_OP_JALR: begin
                w_wb_sel = 2'd1;
                w_wb_en  = (w_rd != 5'd0);
            end
            c_OP_LOAD: begin
                w_wb_sel   = 2'd2;
                w_load_sel = instruction_x[14:12];
                w_wb_en    = (w_rd != 5'd0);
                // Unmapped regions fall back to DMEM but never write the register file
                casez (alu_addr_x[31:28])
                    4'b00?1: w_dmem_sel = 2'd1;
                    4'b0100: w_dmem_sel = 2'd2;
                    4'b1000: begin
                        w_dmem_sel = 2'd0;
                        w_is_io    = 1'b1;
                    end
                    default: begin
                        w_dmem_sel = 2'd1;
                        w_wb_en    = 1'b0;
                    end
                endcase
            end
            c_OP_OP, c_OP_OPIMM, c_OP_AUIPC: begin
                w_wb_sel = 2'd3;
                w_wb_en  = (w_rd != 5'd0);
            end
            default: begin
                w_wb_sel = 2'd3;
                w_wb_en  = 1'b0;
            end
        endcase
    end

    // An ack on the final wait cycle takes priority over the timeout
    assign w_timeout = (r_state == S_IO_WAIT) & ~io_ack & (r_wait_cnt == c_WAIT_LAST);
    assign w_stall   = (r_state == S_IO_WAIT) & ~io_ack & ~w_timeout;
    assign w_cap_io  = ~w_stall & valid_x & w_is_io;

    always_comb begin
        w_state_next = r_state;
        if (w_cap_io) begin
            w_state_next = S_IO_WAIT;
        end else if ((r_state == S_IO_WAIT) && (io_ack || w_timeout)) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 16'd0;
            r_io_req   <= 1'b0;
            r_io_err   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_io_req <= w_cap_io;
            if (w_cap_io) begin
                r_wait_cnt <= 16'd0;
            end else if ((r_state == S_IO_WAIT) && !io_ack) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_io_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_sel <= 2'd0;
            r_load_sel <= 3'd0;
            r_wb_sel   <= 2'd0;
            r_wb_en    <= 1'b0;
            r_rd       <= 5'd0;
        end else if (!w_stall) begin
            if (valid_x) begin
                r_dmem_sel <= w_dmem_sel;
                r_load_sel <= w_load_sel;
                r_wb_sel   <= w_wb_sel;
                r_wb_en    <= w_wb_en;
                r_rd       <= w_rd;
            end else begin
                r_dmem_sel <= 2'd0;
                r_load_sel <= 3'd0;
                r_wb_sel   <= 2'd0;
                r_wb_en    <= 1'b0;
                r_rd       <= 5'd0;
            end
        end
    end

    assign DMEM_sel = r_dmem_sel;
    assign LOAD_sel = r_load_sel;
    assign WB_sel   = r_wb_sel;
    assign rd_wb    = r_rd;
    assign wb_en    = r_wb_en & ((r_state == S_IDLE) | io_ack) & ~w_timeout;
    assign io_req   = r_io_req;
    assign stall    = w_stall;
    assign io_err   = r_io_err;

endmodule
`default_nettype wire
